// File: rtl/pcs_rx_decoder_fsm_pkg.sv
// Shared 100GBASE-R definitions for the RX decoder: CGMII/PCS characters, block types,
// R_TYPE and receive-state encodings, and the LBLOCK_R/EBLOCK_R constants.
package pcs_rx_decoder_fsm_pkg;

    localparam int LEN_CODED_BLOCK = 66;
    localparam int LEN_RX_DATA     = 64;
    localparam int LEN_RX_CTRL     = 8;
    localparam int NB_ERR_CNT      = 16;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_S    = 8'h78;
    localparam logic [7:0] BT_O    = 8'h4B;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;

    localparam logic [7:0] CG_IDLE  = 8'h07;
    localparam logic [7:0] CG_ERR   = 8'hFE;
    localparam logic [7:0] CG_START = 8'hFB;
    localparam logic [7:0] CG_TERM  = 8'hFD;
    localparam logic [7:0] CG_SEQ   = 8'h9C;
    localparam logic [7:0] CG_SIG   = 8'h5C;

    localparam logic [6:0] PC_IDLE = 7'h00;
    localparam logic [6:0] PC_ERR  = 7'h1E;

    localparam logic [63:0] LBLOCK_DATA = 64'h9C00_0001_0000_0000;
    localparam logic [7:0]  LBLOCK_CTRL = 8'h80;
    localparam logic [63:0] EBLOCK_DATA = {8{CG_ERR}};
    localparam logic [7:0]  EBLOCK_CTRL = 8'hFF;

    typedef enum logic [2:0] {R_C, R_D, R_S, R_T, R_E} r_type_e;

    typedef enum logic [2:0] {
        RX_INIT = 3'd0,
        RX_C    = 3'd1,
        RX_D    = 3'd2,
        RX_T    = 3'd3,
        RX_E    = 3'd4
    } rx_state_e;

    function automatic logic char_ok(input logic [6:0] c);
        return (c == PC_IDLE) || (c == PC_ERR);
    endfunction

    function automatic logic [7:0] map_char(input logic [6:0] c);
        return (c == PC_ERR) ? CG_ERR : CG_IDLE;
    endfunction

    // Number of data bytes ahead of /T/, or -1 when the type is not a terminate.
    function automatic int term_bytes(input logic [7:0] bt);
        case (bt)
            BT_T0:   return 0;
            BT_T1:   return 1;
            BT_T2:   return 2;
            BT_T3:   return 3;
            BT_T4:   return 4;
            BT_T5:   return 5;
            BT_T6:   return 6;
            BT_T7:   return 7;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/pcs_rx_decoder_fsm_block_classify.sv
// Combinational 66b block classifier: R_TYPE plus the CGMII data/ctrl the block decodes to.
module pcs_rx_block_classify
    import pcs_rx_decoder_fsm_pkg::*;
(
    input  logic [LEN_CODED_BLOCK-1:0] block,
    output logic [2:0]                 r_type,
    output logic [LEN_RX_DATA-1:0]     data,
    output logic [LEN_RX_CTRL-1:0]     ctrl
);
    logic [1:0]  sh;
    logic [7:0]  btype;
    logic [55:0] pl;
    logic [63:0] pl_pad;
    logic        chars_ok;
    int          n_term;

    assign sh     = block[65:64];
    assign btype  = block[63:56];
    assign pl     = block[55:0];
    assign pl_pad = {pl, 8'h00};

    always_comb begin
        r_type   = R_E;
        data     = EBLOCK_DATA;
        ctrl     = EBLOCK_CTRL;
        chars_ok = 1'b1;
        n_term   = term_bytes(btype);
        if (sh == SH_DATA) begin
            r_type = R_D;
            data   = block[63:0];
            ctrl   = '0;
        end else if (sh == SH_CTRL) begin
            if (btype == BT_IDLE) begin
                for (int i = 0; i < 8; i++) begin
                    chars_ok          = chars_ok & char_ok(pl[55-7*i -: 7]);
                    data[63-8*i -: 8] = map_char(pl[55-7*i -: 7]);
                end
                ctrl = 8'hFF;
                if (chars_ok) r_type = R_C;
            end else if (btype == BT_S) begin
                r_type = R_S;
                data   = {CG_START, pl};
                ctrl   = 8'h80;
            end else if (btype == BT_O) begin
                data = {(pl[31:28] == 4'hF) ? CG_SIG : CG_SEQ, pl[55:32], 32'h0};
                ctrl = 8'h80;
                if ((pl[31:28] == 4'h0 || pl[31:28] == 4'hF) && pl[27:0] == 28'h0)
                    r_type = R_C;
            end else if (n_term >= 0) begin
                // Data bytes, then /T/, then 7-bit trailing chars packed at the bottom.
                for (int i = 0; i < 8; i++) begin
                    if (i < n_term) begin
                        data[63-8*i -: 8] = pl_pad[63-8*i -: 8];
                    end else if (i == n_term) begin
                        data[63-8*i -: 8] = CG_TERM;
                    end else begin
                        chars_ok          = chars_ok & char_ok(pl[7*(7-i) +: 7]);
                        data[63-8*i -: 8] = map_char(pl[7*(7-i) +: 7]);
                    end
                end
                ctrl = 8'hFF >> n_term;
                if (chars_ok) r_type = R_T;
            end
        end
    end

endmodule

// File: rtl/pcs_rx_decoder_fsm.sv
// 100GBASE-R receive decoder: one-block-lookahead receive state machine driving CGMII RX,
// with LBLOCK_R while unlocked and a saturating errored-block counter.
module pcs_rx_decoder_fsm
    import pcs_rx_decoder_fsm_pkg::*;
(
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [LEN_CODED_BLOCK-1:0] i_rx_coded,
    input  logic                       i_valid,
    input  logic                       i_block_lock,
    input  logic                       i_hi_ber,
    input  logic                       i_err_clr,
    output logic [LEN_RX_DATA-1:0]     o_rx_data,
    output logic [LEN_RX_CTRL-1:0]     o_rx_ctrl,
    output logic                       o_valid,
    output logic [2:0]                 o_state,
    output logic [NB_ERR_CNT-1:0]      o_err_count
);
    logic [LEN_CODED_BLOCK-1:0] cur_q;
    logic                       cur_vld_q, cur_vld_d;
    rx_state_e                  state_q, state_d, dec;
    logic [LEN_RX_DATA-1:0]     data_q, data_d;
    logic [LEN_RX_CTRL-1:0]     ctrl_q, ctrl_d;
    logic                       vld_q, vld_d;
    logic [NB_ERR_CNT-1:0]      err_q, err_d;
    logic                       err_inc;
    logic                       lock_ok, load_cur, nxt_sc;

    logic [2:0]             cur_type, nxt_type;
    logic [LEN_RX_DATA-1:0] cur_data, nxt_data;
    logic [LEN_RX_CTRL-1:0] cur_ctrl, nxt_ctrl;
    logic                   unused_nxt;

    pcs_rx_block_classify u_cls_cur (
        .block  (cur_q),
        .r_type (cur_type),
        .data   (cur_data),
        .ctrl   (cur_ctrl)
    );

    // Lookahead instance: only its type is consumed.
    pcs_rx_block_classify u_cls_nxt (
        .block  (i_rx_coded),
        .r_type (nxt_type),
        .data   (nxt_data),
        .ctrl   (nxt_ctrl)
    );

    assign unused_nxt = ^{nxt_data, nxt_ctrl};
    assign lock_ok    = i_block_lock & ~i_hi_ber;
    assign load_cur   = lock_ok & i_valid;
    assign nxt_sc     = (nxt_type == R_S) || (nxt_type == R_C);

    always_comb begin
        dec       = RX_E;
        state_d   = state_q;
        cur_vld_d = cur_vld_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        vld_d     = 1'b0;
        err_inc   = 1'b0;

        case (state_q)
            RX_INIT, RX_C, RX_T: begin
                if (cur_type == R_C)      dec = RX_C;
                else if (cur_type == R_S) dec = RX_D;
            end
            RX_D: begin
                if (cur_type == R_D)                 dec = RX_D;
                else if (cur_type == R_T && nxt_sc)  dec = RX_T;
            end
            RX_E: begin
                if (cur_type == R_C)                 dec = RX_C;
                else if (cur_type == R_D)            dec = RX_D;
                else if (cur_type == R_T && nxt_sc)  dec = RX_T;
            end
            default: dec = RX_E;
        endcase

        if (!lock_ok) begin
            state_d   = RX_INIT;
            cur_vld_d = 1'b0;
            if (i_valid) begin
                data_d = LBLOCK_DATA;
                ctrl_d = LBLOCK_CTRL;
                vld_d  = 1'b1;
            end
        end else if (i_valid) begin
            cur_vld_d = 1'b1;
            // First beat after reset/relock only primes the lookahead.
            if (cur_vld_q) begin
                state_d = dec;
                vld_d   = 1'b1;
                if (dec == RX_E) begin
                    data_d  = EBLOCK_DATA;
                    ctrl_d  = EBLOCK_CTRL;
                    err_inc = 1'b1;
                end else begin
                    data_d = cur_data;
                    ctrl_d = cur_ctrl;
                end
            end
        end

        if (i_err_clr)                    err_d = '0;
        else if (err_inc && err_q != '1)  err_d = err_q + 1'b1;
        else                              err_d = err_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= RX_INIT;
            cur_q     <= '0;
            cur_vld_q <= 1'b0;
            data_q    <= LBLOCK_DATA;
            ctrl_q    <= LBLOCK_CTRL;
            vld_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_vld_q <= cur_vld_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            vld_q     <= vld_d;
            err_q     <= err_d;
            if (load_cur) cur_q <= i_rx_coded;
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_ctrl   = ctrl_q;
    assign o_valid     = vld_q;
    assign o_state     = state_q;
    assign o_err_count = err_q;

endmodule

// File: tb/tb_pcs_rx_decoder_fsm.sv
// Directed bench for pcs_rx_decoder_fsm: hand-computed vectors plus a gapped random-frame stream.
module tb_pcs_rx_decoder_fsm;

    logic        i_clock, i_reset, i_valid, i_block_lock, i_hi_ber, i_err_clr;
    logic [65:0] i_rx_coded;
    logic [63:0] o_rx_data;
    logic [7:0]  o_rx_ctrl;
    logic        o_valid;
    logic [2:0]  o_state;
    logic [15:0] o_err_count;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] LB   = 64'h9C00_0001_0000_0000;
    localparam logic [63:0] EB   = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] IDL  = 64'h0707_0707_0707_0707;
    localparam logic [65:0] B_C  = {2'b10, 8'h1E, 56'h0};
    localparam logic [65:0] B_S  = {2'b10, 8'h78, 56'h11_2233_4455_6677};
    localparam logic [63:0] D1   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D3   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D4   = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D5   = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [65:0] B_T3 = {2'b10, 8'hB4, 24'hA0A1A2, 32'h0};
    localparam logic [65:0] B_T7A = {2'b10, 8'hFF, 56'hC0_C1C2_C3C4_C5C6};
    localparam logic [65:0] B_T7B = {2'b10, 8'hFF, 56'hB0_B1B2_B3B4_B5B6};
    localparam logic [65:0] B_X55 = {2'b10, 8'h55, 56'h0};
    localparam logic [65:0] B_SH11 = {2'b11, 64'h0};

    pcs_rx_decoder_fsm dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_coded   (i_rx_coded),
        .i_valid      (i_valid),
        .i_block_lock (i_block_lock),
        .i_hi_ber     (i_hi_ber),
        .i_err_clr    (i_err_clr),
        .o_rx_data    (o_rx_data),
        .o_rx_ctrl    (o_rx_ctrl),
        .o_valid      (o_valid),
        .o_state      (o_state),
        .o_err_count  (o_err_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic exp_all(input string tag, input logic v, input logic [63:0] d,
                           input logic [7:0] c, input logic [2:0] st, input logic [15:0] e);
        chk({tag, ".vld"},   80'(o_valid),     80'(v));
        chk({tag, ".data"},  80'(o_rx_data),   80'(d));
        chk({tag, ".ctrl"},  80'(o_rx_ctrl),   80'(c));
        chk({tag, ".state"}, 80'(o_state),     80'(st));
        chk({tag, ".err"},   80'(o_err_count), 80'(e));
    endtask

    task automatic cyc(input logic v, input logic [65:0] blk);
        @(negedge i_clock);
        i_valid    = v;
        i_rx_coded = blk;
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        logic [65:0] blk_q[$];
        logic [71:0] exp_q[$];
        logic [7:0]  tt [8];
        logic [31:0] r0, r1;
        logic [55:0] pl, tp;
        logic [63:0] ed;
        int          n;

        tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        i_reset = 1'b1; i_valid = 1'b0; i_block_lock = 1'b1; i_hi_ber = 1'b0;
        i_err_clr = 1'b0; i_rx_coded = '0;
        repeat (3) @(posedge i_clock);
        #1;
        exp_all("reset", 1'b0, LB, 8'h80, 3'd0, 16'd0);
        @(negedge i_clock);
        i_reset = 1'b0;

        // Idle, S, D, D, T3, idle frame
        cyc(1'b1, B_C);            chk("prime.vld", 80'(o_valid), 80'(0));
        cyc(1'b1, B_S);            exp_all("c0", 1'b1, IDL, 8'hFF, 3'd1, 16'd0);
        cyc(1'b1, {2'b01, D1});    exp_all("s", 1'b1, 64'hFB11_2233_4455_6677, 8'h80, 3'd2, 16'd0);
        cyc(1'b1, {2'b01, D2});    exp_all("d1", 1'b1, D1, 8'h00, 3'd2, 16'd0);
        cyc(1'b1, B_T3);           exp_all("d2", 1'b1, D2, 8'h00, 3'd2, 16'd0);
        cyc(1'b1, B_C);            exp_all("t3", 1'b1, 64'hA0A1_A2FD_0707_0707, 8'h1F, 3'd3, 16'd0);
        cyc(1'b1, {2'b01, D3});    exp_all("c1", 1'b1, IDL, 8'hFF, 3'd1, 16'd0);
        // D after C is a sequence error; a following D recovers
        cyc(1'b1, {2'b01, D4});    exp_all("d_after_c", 1'b1, EB, 8'hFF, 3'd4, 16'd1);
        cyc(1'b1, B_T7A);          exp_all("recover_d", 1'b1, D4, 8'h00, 3'd2, 16'd1);
        cyc(1'b1, {2'b01, D5});    exp_all("t7_then_d", 1'b1, EB, 8'hFF, 3'd4, 16'd2);
        cyc(1'b1, B_X55);          exp_all("d5", 1'b1, D5, 8'h00, 3'd2, 16'd2);
        cyc(1'b1, B_T7B);          exp_all("bad_type", 1'b1, EB, 8'hFF, 3'd4, 16'd3);
        cyc(1'b1, B_C);            exp_all("t7_from_e", 1'b1, 64'hB0B1_B2B3_B4B5_B6FD, 8'h01, 3'd3, 16'd3);
        cyc(1'b1, B_C);            exp_all("c2", 1'b1, IDL, 8'hFF, 3'd1, 16'd3);
        cyc(1'b0, {2'b01, D1});    exp_all("hold", 1'b0, IDL, 8'hFF, 3'd1, 16'd3);

        // Lock loss for three beats
        i_block_lock = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, {2'b01, D2});
            exp_all("unlock", 1'b1, LB, 8'h80, 3'd0, 16'd3);
        end
        i_block_lock = 1'b1;
        cyc(1'b1, B_C);            exp_all("relock_prime", 1'b0, LB, 8'h80, 3'd0, 16'd3);
        cyc(1'b1, B_C);            exp_all("relock_c", 1'b1, IDL, 8'hFF, 3'd1, 16'd3);
        i_hi_ber = 1'b1;
        cyc(1'b1, {2'b01, D1});    exp_all("hi_ber", 1'b1, LB, 8'h80, 3'd0, 16'd3);
        i_hi_ber = 1'b0;
        cyc(1'b1, B_C);            chk("ber_prime.vld", 80'(o_valid), 80'(0));
        cyc(1'b1, B_SH11);         exp_all("c3", 1'b1, IDL, 8'hFF, 3'd1, 16'd3);
        cyc(1'b1, B_C);            exp_all("sh11", 1'b1, EB, 8'hFF, 3'd4, 16'd4);

        // Saturation: stream sh=11 blocks back to back
        cyc(1'b1, B_SH11);         exp_all("c4", 1'b1, IDL, 8'hFF, 3'd1, 16'd4);
        repeat (65530) @(posedge i_clock);
        #1;
        chk("cnt_fffe", 80'(o_err_count), 80'(16'hFFFE));
        repeat (3) @(posedge i_clock);
        #1;
        chk("cnt_sat", 80'(o_err_count), 80'(16'hFFFF));
        chk("sat.state", 80'(o_state), 80'(3'd4));
        i_err_clr = 1'b1;
        cyc(1'b1, B_SH11);         chk("clr_wins", 80'(o_err_count), 80'(0));
        i_err_clr = 1'b0;
        cyc(1'b1, B_SH11);         chk("cnt_after_clr", 80'(o_err_count), 80'(1));

        // Reset mid-frame
        i_reset = 1'b1;
        cyc(1'b1, {2'b01, D1});    exp_all("reset_mid", 1'b0, LB, 8'h80, 3'd0, 16'd0);
        i_reset = 1'b0;

        // 1000 legal frames with random valid gaps
        blk_q.push_back(B_C); exp_q.push_back({IDL, 8'hFF});
        for (int f = 0; f < 1000; f++) begin
            r0 = $urandom; r1 = $urandom; pl = {r0, r1[23:0]};
            blk_q.push_back({2'b10, 8'h78, pl}); exp_q.push_back({8'hFB, pl, 8'h80});
            n = $urandom_range(0, 2);
            for (int d = 0; d < n; d++) begin
                r0 = $urandom; r1 = $urandom;
                blk_q.push_back({2'b01, r0, r1}); exp_q.push_back({r0, r1, 8'h00});
            end
            n = $urandom_range(0, 7);
            r0 = $urandom; r1 = $urandom; pl = {r0, r1[23:0]};
            tp = pl & ~({56{1'b1}} >> (8*n));
            ed = {tp, 8'h00} | (IDL & ({64{1'b1}} >> (8*n)));
            ed[63-8*n -: 8] = 8'hFD;
            blk_q.push_back({2'b10, tt[n], tp}); exp_q.push_back({ed, 8'hFF >> n});
            n = $urandom_range(1, 2);
            for (int c = 0; c < n; c++) begin
                blk_q.push_back(B_C); exp_q.push_back({IDL, 8'hFF});
            end
        end
        blk_q.push_back(B_C);

        for (int k = 0; k < blk_q.size(); k++) begin
            if ($urandom_range(0, 1) == 1) begin
                r0 = $urandom; r1 = $urandom;
                cyc(1'b0, {2'b01, r0, r1});
                chk("gap.vld", 80'(o_valid), 80'(0));
            end
            cyc(1'b1, blk_q[k]);
            if (k == 0) chk("rnd.prime", 80'(o_valid), 80'(0));
            else        chk("rnd.out", 80'({o_valid, o_rx_data, o_rx_ctrl}), 80'({1'b1, exp_q[k-1]}));
        end
        chk("rnd.err", 80'(o_err_count), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
